// File: rtl/derandomizer_rx_if.sv
// Serial-in / byte-out bus of the receive derandomizer.
// The master drives the scrambled bit stream and seed writes; the slave returns bytes and status.
interface derandomizer_rx_if;
  logic        in_valid;
  logic        in_bit;
  logic        sof;
  logic        load;
  logic [14:0] vect;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_last;
  logic        busy;
  logic        err_sof;

  modport master (
    output in_valid, in_bit, sof, load, vect,
    input  out_byte, out_valid, out_last, busy, err_sof
  );

  modport slave (
    input  in_valid, in_bit, sof, load, vect,
    output out_byte, out_valid, out_last, busy, err_sof
  );
endinterface

// File: rtl/derandomizer_rx.sv
// Receive derandomizer: strips the x^15+x^14+1 PRBS keystream from a serial stream,
// re-seeding at every start-of-frame, and packs recovered bits LSB-first into bytes.
module derandomizer_rx #(
  parameter logic [14:0] SEED       = 15'b011_0111_0001_0101,
  parameter int          FRAME_BITS = 96
) (
  input  logic              clk,
  input  logic              reset,
  derandomizer_rx_if.slave  bus
);

  localparam int CW = $clog2(FRAME_BITS);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [14:0]     seed_q, seed_d;
  logic [14:0]     lfsr_q, lfsr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      sh_q, sh_d;
  logic [7:0]      out_byte_q, out_byte_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic            err_sof_q, err_sof_d;
  logic            d_s;
  logic [7:0]      byte_s;

  function automatic logic keybit(input logic [14:0] p);
    return p[0] ^ p[1];
  endfunction

  function automatic logic [14:0] prbs_next(input logic [14:0] p);
    return {p[0] ^ p[1], p[14:1]};
  endfunction

  // Next-state, descramble and byte assembly
  always_comb begin
    state_d     = state_q;
    seed_d      = seed_q;
    lfsr_d      = lfsr_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    out_byte_d  = out_byte_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    err_sof_d   = 1'b0;
    d_s         = 1'b0;
    byte_s      = sh_q;

    // A seed written here only reaches the LFSR at the next sof, so a frame in flight is unaffected.
    if (bus.load) begin
      seed_d = bus.vect;
    end else begin
      seed_d = seed_q;
    end

    if (bus.in_valid && bus.sof) begin
      // Any sof restarts a frame; mid-frame it drops the partial byte and flags the error.
      d_s       = bus.in_bit ^ keybit(seed_q);
      err_sof_d = (state_q == RUN);
      lfsr_d    = prbs_next(seed_q);
      sh_d      = {7'd0, d_s};
      cnt_d     = CW'(1'b1);
      state_d   = RUN;
    end else if (bus.in_valid && (state_q == RUN)) begin
      d_s                 = bus.in_bit ^ keybit(lfsr_q);
      byte_s[cnt_q[2:0]]  = d_s;
      sh_d                = byte_s;
      lfsr_d              = prbs_next(lfsr_q);
      if (cnt_q[2:0] == 3'd7) begin
        out_valid_d = 1'b1;
        out_byte_d  = byte_s;
      end else begin
        out_valid_d = 1'b0;
      end
      if (cnt_q == CW'(FRAME_BITS - 1)) begin
        out_last_d = 1'b1;
        state_d    = IDLE;
        cnt_d      = {CW{1'b0}};
      end else begin
        cnt_d      = cnt_q + CW'(1'b1);
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      seed_q      <= SEED;
      lfsr_q      <= SEED;
      cnt_q       <= {CW{1'b0}};
      sh_q        <= 8'd0;
      out_byte_q  <= 8'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      err_sof_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      seed_q      <= seed_d;
      lfsr_q      <= lfsr_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      out_byte_q  <= out_byte_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      err_sof_q   <= err_sof_d;
    end
  end

  assign bus.out_byte  = out_byte_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.err_sof   = err_sof_q;
  assign bus.busy      = (state_q == RUN);

endmodule

// File: tb/tb_derandomizer_rx.sv
// Directed bench for derandomizer_rx: a frame-level keystream model checked every cycle,
// plus hand-computed byte values that pin the model itself.
module tb_derandomizer_rx;

  localparam int          FB   = 96;
  localparam logic [14:0] SEED = 15'b011_0111_0001_0101;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  derandomizer_rx_if bus ();

  derandomizer_rx #(.SEED(SEED), .FRAME_BITS(FB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [14:0] m_seed;
  bit          m_key[$];
  int          m_pos;
  int          m_nbits;
  bit          m_busy;
  logic [7:0]  m_acc;
  logic [7:0]  m_byte;
  bit          m_valid, m_last, m_err;

  logic [7:0]  got_b[$];
  bit          got_l[$];
  int          n_err;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_byte(input string name, input int idx, input logic [7:0] exp);
    checks++;
    if (idx >= got_b.size()) begin
      errors++;
      $display("FAIL %s: byte %0d missing, expected %h", name, idx, exp);
    end else if (got_b[idx] !== exp) begin
      errors++;
      $display("FAIL %s: byte %0d got %h expected %h", name, idx, got_b[idx], exp);
    end
  endtask

  // Keystream of a whole frame from the bit-sequence view: s[i+15] = s[i]^s[i+1], k[t] = s[t]^s[t+1].
  task automatic gen_key(input logic [14:0] sd, output bit k[$]);
    bit          s[$];
    logic [14:0] t;
    t = sd;
    k.delete();
    repeat (15) begin
      s.push_back(t[0]);
      t = t >> 1;
    end
    for (int i = 0; s.size() < FB + 1; i++) s.push_back(s[i] ^ s[i+1]);
    for (int i = 0; i < FB; i++) k.push_back(s[i] ^ s[i+1]);
  endtask

  task automatic model_reset();
    m_seed  = SEED;
    m_busy  = 1'b0;
    m_pos   = 0;
    m_nbits = 0;
    m_acc   = 8'd0;
    m_byte  = 8'd0;
    m_valid = 1'b0;
    m_last  = 1'b0;
    m_err   = 1'b0;
    m_key.delete();
  endtask

  task automatic model_step(input bit v, input bit b, input bit s, input bit ld, input logic [14:0] vc);
    m_valid = 1'b0;
    m_last  = 1'b0;
    m_err   = 1'b0;
    if (v) begin
      if (s) begin
        m_err = m_busy;
        gen_key(m_seed, m_key);
        m_pos   = 0;
        m_nbits = 0;
        m_busy  = 1'b1;
      end
      if (m_busy) begin
        m_acc = {b ^ m_key[m_pos], m_acc[7:1]};
        m_pos++;
        m_nbits++;
        if (m_nbits == 8) begin
          m_byte  = m_acc;
          m_valid = 1'b1;
          m_nbits = 0;
        end
        if (m_pos == FB) begin
          m_last = 1'b1;
          m_busy = 1'b0;
        end
      end
    end
    if (ld) m_seed = vc;
  endtask

  task automatic compare_all();
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("out_last",  32'(bus.out_last),  32'(m_last));
    chk("err_sof",   32'(bus.err_sof),   32'(m_err));
    chk("busy",      32'(bus.busy),      32'(m_busy));
    chk("out_byte",  32'(bus.out_byte),  32'(m_byte));
    if (bus.out_valid) begin
      got_b.push_back(bus.out_byte);
      got_l.push_back(bus.out_last);
    end
    if (bus.err_sof) n_err++;
  endtask

  task automatic drive(input bit v, input bit b, input bit s, input bit ld, input logic [14:0] vc);
    bus.in_valid = v;
    bus.in_bit   = b;
    bus.sof      = s;
    bus.load     = ld;
    bus.vect     = vc;
    @(posedge clk);
    model_step(v, b, s, ld, vc);
    @(negedge clk);
    compare_all();
  endtask

  task automatic clear_cap();
    got_b.delete();
    got_l.delete();
    n_err = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 15'd0);
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
    bus.sof      = 1'b0;
    bus.load     = 1'b0;
    bus.vect     = 15'd0;
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    compare_all();
  endtask

  task automatic zero_bits(input int n, input bit first_sof);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, first_sof && (i == 0), 1'b0, 15'd0);
  endtask

  // Transmitter side: bytes 0..11 LSB-first, scrambled with the reset-seed keystream.
  task automatic tx_frame(input bit gaps);
    bit         k[$];
    logic [7:0] d;
    gen_key(SEED, k);
    for (int i = 0; i < FB / 8; i++) begin
      d = 8'(i);
      for (int j = 0; j < 8; j++) begin
        drive(1'b1, d[0] ^ k[8*i + j], (i == 0) && (j == 0), 1'b0, 15'd0);
        d = d >> 1;
        if (gaps) drive(1'b0, 1'b1, 1'b1, 1'b0, 15'd0);
      end
    end
    idle(3);
  endtask

  task automatic check_roundtrip(input string tag);
    chk({tag, "_count"}, 32'(got_b.size()), 32'd12);
    for (int i = 0; i < FB / 8; i++) begin
      chk_byte({tag, "_byte"}, i, 8'(i));
      if (i < got_l.size()) chk({tag, "_last"}, 32'(got_l[i]), 32'(i == FB / 8 - 1));
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
    bus.sof      = 1'b0;
    bus.load     = 1'b0;
    bus.vect     = 15'd0;
    model_reset();
    clear_cap();

    // 1: reset state, then all-zero input gives the raw keystream bytes
    do_reset();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_byte",  32'(bus.out_byte),  32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    clear_cap();
    zero_bits(16, 1'b1);
    idle(1);
    chk("t1_count", 32'(got_b.size()), 32'd2);
    chk_byte("t1_b0", 0, 8'h9F);
    chk_byte("t1_b1", 1, 8'h6C);
    if (got_l.size() >= 2) chk("t1_last", 32'(got_l[0] | got_l[1]), 32'd0);

    // 2: round trip through the transmitter keystream
    do_reset();
    clear_cap();
    tx_frame(1'b0);
    check_roundtrip("t2");
    chk("t2_busy_after", 32'(bus.busy), 32'd0);

    // 3: same frame with in_valid toggling, junk on in_bit/sof in the gaps
    clear_cap();
    tx_frame(1'b1);
    check_roundtrip("t3");

    // 4a: runtime seed loaded in IDLE
    clear_cap();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 15'h0001);
    zero_bits(FB, 1'b1);
    idle(2);
    chk("t4a_count", 32'(got_b.size()), 32'd12);
    chk_byte("t4a_b0", 0, 8'h01);
    chk_byte("t4a_b1", 1, 8'hC0);

    // 4b: load with sof and again mid-frame leaves the current frame on the old seed
    do_reset();
    clear_cap();
    for (int i = 0; i < FB; i++) drive(1'b1, 1'b0, i == 0, (i == 0) || (i == 20), 15'h0001);
    idle(2);
    chk_byte("t4b_b0", 0, 8'h9F);
    chk_byte("t4b_b1", 1, 8'h6C);
    clear_cap();
    zero_bits(16, 1'b1);
    idle(1);
    chk_byte("t4b_next_b0", 0, 8'h01);

    // 5: sof re-asserted at bit 13 of a frame
    do_reset();
    clear_cap();
    zero_bits(13, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 15'd0);
    zero_bits(15, 1'b0);
    idle(1);
    chk("t5_err_pulses", 32'(n_err), 32'd1);
    chk("t5_count", 32'(got_b.size()), 32'd3);
    chk_byte("t5_b0", 0, 8'h9F);
    chk_byte("t5_b1", 1, 8'h9F);
    chk_byte("t5_b2", 2, 8'h6C);

    // 6: asynchronous reset at bit 40, then a clean frame
    do_reset();
    clear_cap();
    zero_bits(40, 1'b1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("t6_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_out_last",  32'(bus.out_last),  32'd0);
    chk("t6_out_byte",  32'(bus.out_byte),  32'd0);
    chk("t6_busy",      32'(bus.busy),      32'd0);
    chk("t6_err_sof",   32'(bus.err_sof),   32'd0);
    @(negedge clk);
    reset = 1'b0;
    compare_all();
    clear_cap();
    zero_bits(16, 1'b1);
    idle(1);
    chk_byte("t6_b0", 0, 8'h9F);
    chk_byte("t6_b1", 1, 8'h6C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
